// File: rtl/aes256_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the AES-256
// coprocessor controller.
package aes256_pkg;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_KEY7   = 4'd7;
  localparam logic [3:0] ADDR_NONCE0 = 4'd8;
  localparam logic [3:0] ADDR_NONCE1 = 4'd9;
  localparam logic [3:0] ADDR_NONCE2 = 4'd10;
  localparam logic [3:0] ADDR_NONCE3 = 4'd11;
  localparam logic [3:0] ADDR_CTRL   = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;
  localparam logic [3:0] ADDR_BLKCNT = 4'd14;
  localparam logic [3:0] ADDR_DATA   = 4'd15;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_STOP   = 1;
  localparam int unsigned CTRL_CLRCNT = 2;
  localparam int unsigned CTRL_CLRERR = 3;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_OVF      = 1;
  localparam int unsigned STAT_UNF      = 2;
  localparam int unsigned STAT_KEYERR   = 3;
  localparam int unsigned STAT_INWFULL  = 4;
  localparam int unsigned STAT_OUTWEMPT = 5;
  localparam int unsigned STAT_INBEMPT  = 6;
  localparam int unsigned STAT_OUTBFULL = 7;

  typedef enum logic [1:0] {
    StIdle,
    StSetKey,
    StSetNonce,
    StActive
  } state_e;

endpackage

// File: rtl/aes256_run_pacer.sv
// Paces run strobes against the core occupancy gap and the block FIFO flags, and counts
// issued blocks.
module aes256_run_pacer
  import aes256_pkg::*;
#(
  parameter int unsigned RUN_GAP = 4,
  parameter int unsigned CNTW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            active_i,
  input  logic            in_blk_empty_i,
  input  logic            out_blk_full_i,
  input  logic            clr_cnt_i,
  output logic            run_o,
  output logic [CNTW-1:0] blk_cnt_o
);

  localparam int unsigned GapW = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(RUN_GAP - 1);

  logic [GapW-1:0] gap_q, gap_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    // Gated by reset so a reset cycle in ACTIVE never issues a block.
    run_o = active_i && (gap_q == '0) && !in_blk_empty_i && !out_blk_full_i && !rst_i;

    gap_d = gap_q;
    if (!active_i) begin
      gap_d = '0;
    end else if (run_o) begin
      gap_d = GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end

    // Clear first so a simultaneous run leaves the count at one.
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end
    if (run_o) begin
      cnt_d = cnt_d + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q <= '0;
      cnt_q <= '0;
    end else begin
      gap_q <= gap_d;
      cnt_q <= cnt_d;
    end
  end

  assign blk_cnt_o = cnt_q;

endmodule

// File: rtl/aes256_ctrl.sv
// Bus-facing controller for the AES-256 datapath: key/nonce registers, load sequencing,
// run pacing, word FIFO forwarding and status/error reporting.
module aes256_ctrl
  import aes256_pkg::*;
#(
  parameter int unsigned KEYW    = 256,
  parameter int unsigned NONCEW  = 128,
  parameter int unsigned RUN_GAP = 4,
  parameter int unsigned CNTW    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [31:0]       bus_rdata,
  output logic [KEYW-1:0]   key_dataout,
  output logic              setkey_ctrout,
  output logic [NONCEW-1:0] nonce_dataout,
  output logic              setnonce_ctrout,
  output logic              run_ctrout,
  output logic [31:0]       user_dataout,
  output logic              wren_ctrout,
  output logic              rden_ctrout,
  input  logic [31:0]       user_datain,
  input  logic              inwordfifofull_ctrin,
  input  logic              outwordfifoempty_ctrin,
  input  logic              inblockfifoempty_ctrin,
  input  logic              outblockfifofull_ctrin,
  output logic              busy,
  output logic              irq
);

  state_e state_q;
  logic   setkey_q, setnonce_q;

  logic [KEYW/32-1:0][31:0]   key_q;
  logic [NONCEW/32-1:0][31:0] nonce_q;
  logic ovf_q, ovf_d, unf_q, unf_d, keyerr_q, keyerr_d;

  logic key_sel, nonce_sel, ctrl_wr, data_wr, data_rd;
  logic start, stop, clrcnt, clrerr;
  logic [CNTW-1:0] blk_cnt;
  logic [31:0]     status;

  assign busy = (state_q != StIdle);

  always_comb begin
    key_sel   = (bus_addr[3] == 1'b0);
    nonce_sel = (bus_addr[3:2] == 2'b10);
    ctrl_wr   = bus_we && (bus_addr == ADDR_CTRL);
    data_wr   = bus_we && (bus_addr == ADDR_DATA);
    data_rd   = bus_re && (bus_addr == ADDR_DATA);
    // STOP outranks START when both are written together.
    start     = ctrl_wr && bus_wdata[CTRL_START] && !bus_wdata[CTRL_STOP];
    stop      = ctrl_wr && bus_wdata[CTRL_STOP];
    clrcnt    = ctrl_wr && bus_wdata[CTRL_CLRCNT];
    clrerr    = ctrl_wr && bus_wdata[CTRL_CLRERR];

    wren_ctrout  = data_wr && !inwordfifofull_ctrin && !reset;
    rden_ctrout  = data_rd && !outwordfifoempty_ctrin && !reset;
    user_dataout = bus_wdata;

    // A fresh error event in the same cycle as CLRERR keeps its bit set.
    ovf_d    = (ovf_q && !clrerr) || (data_wr && inwordfifofull_ctrin);
    unf_d    = (unf_q && !clrerr) || (data_rd && outwordfifoempty_ctrin);
    keyerr_d = (keyerr_q && !clrerr) || (bus_we && (key_sel || nonce_sel) && busy);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      setkey_q   <= 1'b0;
      setnonce_q <= 1'b0;
    end else begin
      setkey_q   <= 1'b0;
      setnonce_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSetKey;
            setkey_q <= 1'b1;
          end
        end
        StSetKey: begin
          state_q    <= StSetNonce;
          setnonce_q <= 1'b1;
        end
        StSetNonce: state_q <= StActive;
        StActive: begin
          if (stop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q    <= '0;
      nonce_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      keyerr_q <= 1'b0;
    end else begin
      if (bus_we && key_sel && !busy) begin
        key_q[bus_addr[2:0]] <= bus_wdata;
      end
      if (bus_we && nonce_sel && !busy) begin
        nonce_q[bus_addr[1:0]] <= bus_wdata;
      end
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      keyerr_q <= keyerr_d;
    end
  end

  aes256_run_pacer #(
    .RUN_GAP(RUN_GAP),
    .CNTW   (CNTW)
  ) u_run_pacer (
    .clk_i         (clock),
    .rst_i         (reset),
    .active_i      (state_q == StActive),
    .in_blk_empty_i(inblockfifoempty_ctrin),
    .out_blk_full_i(outblockfifofull_ctrin),
    .clr_cnt_i     (clrcnt),
    .run_o         (run_ctrout),
    .blk_cnt_o     (blk_cnt)
  );

  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = busy;
    status[STAT_OVF]      = ovf_q;
    status[STAT_UNF]      = unf_q;
    status[STAT_KEYERR]   = keyerr_q;
    status[STAT_INWFULL]  = inwordfifofull_ctrin;
    status[STAT_OUTWEMPT] = outwordfifoempty_ctrin;
    status[STAT_INBEMPT]  = inblockfifoempty_ctrin;
    status[STAT_OUTBFULL] = outblockfifofull_ctrin;

    bus_rdata = '0;
    if (key_sel) begin
      bus_rdata = key_q[bus_addr[2:0]];
    end else begin
      case (bus_addr)
        ADDR_NONCE0, ADDR_NONCE1, ADDR_NONCE2, ADDR_NONCE3: bus_rdata = nonce_q[bus_addr[1:0]];
        ADDR_STATUS: bus_rdata = status;
        ADDR_BLKCNT: bus_rdata = 32'(blk_cnt);
        ADDR_DATA:   bus_rdata = outwordfifoempty_ctrin ? 32'h0 : user_datain;
        default:     bus_rdata = '0;
      endcase
    end
  end

  assign key_dataout     = key_q;
  assign nonce_dataout   = nonce_q;
  assign setkey_ctrout   = setkey_q;
  assign setnonce_ctrout = setnonce_q;
  assign irq             = ovf_q || unf_q || keyerr_q;

endmodule

// File: tb/tb_aes256_ctrl.sv
// Directed self-checking bench for aes256_ctrl with hand-computed expectations.
module tb_aes256_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_we, bus_re;
  logic [31:0]  bus_rdata;
  logic [255:0] key_dataout;
  logic         setkey_ctrout;
  logic [127:0] nonce_dataout;
  logic         setnonce_ctrout, run_ctrout;
  logic [31:0]  user_dataout;
  logic         wren_ctrout, rden_ctrout;
  logic [31:0]  user_datain;
  logic         inwordfifofull_ctrin, outwordfifoempty_ctrin;
  logic         inblockfifoempty_ctrin, outblockfifofull_ctrin;
  logic         busy, irq;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] ExpKey =
    256'h1c1d1e1f_18191a1b_14151617_10111213_0c0d0e0f_08090a0b_04050607_00010203;
  localparam logic [127:0] ExpNonce = 128'hcafe0003_cafe0002_cafe0001_cafe0000;

  always #5 clock = ~clock;

  aes256_ctrl dut (
    .clock                 (clock),
    .reset                 (reset),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_we                (bus_we),
    .bus_re                (bus_re),
    .bus_rdata             (bus_rdata),
    .key_dataout           (key_dataout),
    .setkey_ctrout         (setkey_ctrout),
    .nonce_dataout         (nonce_dataout),
    .setnonce_ctrout       (setnonce_ctrout),
    .run_ctrout            (run_ctrout),
    .user_dataout          (user_dataout),
    .wren_ctrout           (wren_ctrout),
    .rden_ctrout           (rden_ctrout),
    .user_datain           (user_datain),
    .inwordfifofull_ctrin  (inwordfifofull_ctrin),
    .outwordfifoempty_ctrin(outwordfifoempty_ctrin),
    .inblockfifoempty_ctrin(inblockfifoempty_ctrin),
    .outblockfifofull_ctrin(outblockfifofull_ctrin),
    .busy                  (busy),
    .irq                   (irq)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus write; starts just after a falling edge, returns on the next falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clock);
    bus_we = 1'b0;
  endtask

  initial begin
    logic [255:0] key_mod;
    reset = 1'b1;
    bus_addr = '0;
    bus_wdata = '0;
    bus_we = 1'b0;
    bus_re = 1'b0;
    user_datain = '0;
    inwordfifofull_ctrin = 1'b0;
    outwordfifoempty_ctrin = 1'b1;
    inblockfifoempty_ctrin = 1'b1;
    outblockfifofull_ctrin = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_setkey", setkey_ctrout, 1'b0);
    check("rst_setnonce", setnonce_ctrout, 1'b0);
    check("rst_run", run_ctrout, 1'b0);
    check("rst_wren", wren_ctrout, 1'b0);
    check("rst_rden", rden_ctrout, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_key", key_dataout, '0);
    bus_addr = 4'd13;
    #1 check("rst_status", bus_rdata, 32'h60);
    bus_addr = 4'd14;
    #1 check("rst_blkcnt", bus_rdata, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr(4'(i), {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
    end
    for (int i = 0; i < 4; i++) begin
      wr(4'(8 + i), 32'hcafe0000 | 32'(i));
    end
    #1;
    check("key_out", key_dataout, ExpKey);
    check("nonce_out", nonce_dataout, ExpNonce);
    bus_addr = 4'd3;
    #1 check("key_rd3", bus_rdata, 32'h0c0d0e0f);
    bus_addr = 4'd9;
    #1 check("nonce_rd1", bus_rdata, 32'hcafe0001);

    wr(4'd12, 32'h1);
    #1;
    check("setkey_hi", setkey_ctrout, 1'b1);
    check("setnonce_lo0", setnonce_ctrout, 1'b0);
    check("busy_setkey", busy, 1'b1);
    @(negedge clock);
    #1;
    check("setkey_lo", setkey_ctrout, 1'b0);
    check("setnonce_hi", setnonce_ctrout, 1'b1);
    @(negedge clock);
    inblockfifoempty_ctrin = 1'b0;
    #1;
    check("setnonce_lo1", setnonce_ctrout, 1'b0);
    check("busy_active", busy, 1'b1);

    // First run right after SETNONCE, then one every RUN_GAP cycles.
    for (int k = 0; k < 13; k++) begin
      check("run_pace_a", run_ctrout, (k % 4) == 0);
      @(negedge clock);
      #1;
    end
    outblockfifofull_ctrin = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("run_blocked", run_ctrout, 1'b0);
      @(negedge clock);
      #1;
    end
    outblockfifofull_ctrin = 1'b0;
    #1;
    for (int k = 0; k < 21; k++) begin
      check("run_pace_b", run_ctrout, (k % 4) == 0);
      @(negedge clock);
      #1;
    end
    inblockfifoempty_ctrin = 1'b1;
    bus_addr = 4'd14;
    #1 check("blkcnt_10", bus_rdata, 32'd10);

    // Let the gap drain, then CLRCNT coincides with a run.
    repeat (3) @(negedge clock);
    inblockfifoempty_ctrin = 1'b0;
    bus_addr = 4'd12;
    bus_wdata = 32'h4;
    bus_we = 1'b1;
    #1 check("run_with_clr", run_ctrout, 1'b1);
    @(negedge clock);
    bus_we = 1'b0;
    inblockfifoempty_ctrin = 1'b1;
    bus_addr = 4'd14;
    #1 check("blkcnt_clr_run", bus_rdata, 32'd1);
    wr(4'd12, 32'h4);
    bus_addr = 4'd14;
    #1 check("blkcnt_clr", bus_rdata, 32'd0);

    inwordfifofull_ctrin = 1'b1;
    bus_addr = 4'd15;
    bus_wdata = 32'h12345678;
    bus_we = 1'b1;
    #1 check("wren_full", wren_ctrout, 1'b0);
    @(negedge clock);
    bus_we = 1'b0;
    bus_addr = 4'd13;
    #1;
    check("status_ovf", bus_rdata, 32'h73);
    check("irq_ovf", irq, 1'b1);
    inwordfifofull_ctrin = 1'b0;
    bus_addr = 4'd15;
    bus_wdata = 32'ha5a50f0f;
    bus_we = 1'b1;
    #1;
    check("wren_push", wren_ctrout, 1'b1);
    check("user_dataout", user_dataout, 32'ha5a50f0f);
    @(negedge clock);
    bus_we = 1'b0;
    wr(4'd12, 32'h8);
    bus_addr = 4'd13;
    #1;
    check("status_clrerr", bus_rdata, 32'h61);
    check("irq_clr", irq, 1'b0);

    outwordfifoempty_ctrin = 1'b0;
    user_datain = 32'hdeadbeef;
    bus_addr = 4'd15;
    bus_re = 1'b1;
    #1;
    check("data_rd", bus_rdata, 32'hdeadbeef);
    check("rden_hi", rden_ctrout, 1'b1);
    @(negedge clock);
    bus_re = 1'b0;
    #1 check("rden_lo", rden_ctrout, 1'b0);
    outwordfifoempty_ctrin = 1'b1;
    bus_re = 1'b1;
    #1;
    check("data_rd_empty", bus_rdata, 32'h0);
    check("rden_empty", rden_ctrout, 1'b0);
    @(negedge clock);
    bus_re = 1'b0;
    bus_addr = 4'd13;
    #1;
    check("status_unf", bus_rdata, 32'h65);
    check("irq_unf", irq, 1'b1);

    wr(4'd0, 32'hffffffff);
    #1 check("key_locked", key_dataout, ExpKey);
    bus_addr = 4'd13;
    #1 check("status_keyerr", bus_rdata, 32'h6d);

    wr(4'd12, 32'h3);
    #1;
    check("stop_busy", busy, 1'b0);
    check("stop_setkey", setkey_ctrout, 1'b0);
    @(negedge clock);
    #1 check("stop_setkey2", setkey_ctrout, 1'b0);
    wr(4'd12, 32'h3);
    #1;
    check("stop_over_start", busy, 1'b0);
    check("no_setkey", setkey_ctrout, 1'b0);

    key_mod = ExpKey;
    key_mod[31:0] = 32'hffffffff;
    wr(4'd0, 32'hffffffff);
    #1 check("key_idle_wr", key_dataout, key_mod);
    wr(4'd12, 32'h8);
    bus_addr = 4'd13;
    #1;
    check("status_idle", bus_rdata, 32'h60);
    check("irq_idle", irq, 1'b0);

    // Reset arriving while ACTIVE must suppress that cycle's run.
    wr(4'd12, 32'h1);
    repeat (2) @(negedge clock);
    inblockfifoempty_ctrin = 1'b0;
    reset = 1'b1;
    #1;
    check("busy_pre_rst", busy, 1'b1);
    check("run_in_rst", run_ctrout, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    inblockfifoempty_ctrin = 1'b1;
    #1;
    check("busy_post_rst", busy, 1'b0);
    check("key_post_rst", key_dataout, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes256_ctrl.md
Name: aes256_ctrl

Overview:
Memory-mapped coprocessor controller that sits between the MIPS core's peripheral bus and aes256_datapath. It holds the 256-bit key and 128-bit nonce written word-by-word, sequences the setkey, setnonce and run strobes, and paces block processing against the datapath FIFO flags. It also forwards user data words to and from the datapath word FIFOs and keeps status, error and block-count registers for software polling.

Parameters:
KEYW, 256, key width in bits (KEYW/32 key words)
NONCEW, 128, nonce width in bits
RUN_GAP, 4, minimum cycles from one run strobe to the next (core occupancy); must be ≥1
CNTW, 32, block counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_addr  in  4  word address into register map
bus_wdata  in  32  write data
bus_we  in  1  write strobe, one transfer per cycle
bus_re  in  1  read strobe
bus_rdata  out  32  read data, combinational from bus_addr
key_dataout  out  KEYW  key to datapath
setkey_ctrout  out  1  one-cycle key-load strobe
nonce_dataout  out  NONCEW  nonce to datapath
setnonce_ctrout  out  1  one-cycle nonce-load strobe
run_ctrout  out  1  one-cycle run (pop input block) strobe
user_dataout  out  32  word to datapath input word FIFO
wren_ctrout  out  1  input word FIFO push
rden_ctrout  out  1  output word FIFO pop
user_datain  in  32  word from datapath output word FIFO
inwordfifofull_ctrin, outwordfifoempty_ctrin, inblockfifoempty_ctrin, outblockfifofull_ctrin  in  1 each  datapath FIFO flags
busy  out  1  FSM not in IDLE
irq  out  1  level: any sticky error bit set

Behaviour:
- Register map: 0–7 key words (word 0 = key[31:0]); 8–11 nonce words; 12 CTRL (write: bit0 START, bit1 STOP, bit2 CLRCNT, bit3 CLRERR; reads 0); 13 STATUS (read: bit0 busy, bit1 ovf, bit2 unf, bit3 keyerr, bit4..7 the four FIFO flags); 14 BLKCNT (read); 15 DATA (write pushes a word, read pops a word). Reads of unused bits return 0.
- Reset: key, nonce, block count and error bits = 0; FSM = IDLE. All strobes, busy and irq = 0.
- FSM: IDLE → SETKEY → SETNONCE → ACTIVE.
  - IDLE → SETKEY on a START write.
  - SETKEY: setkey_ctrout=1 for exactly 1 cycle.
  - SETNONCE: setnonce_ctrout=1 for exactly 1 cycle.
  - ACTIVE → IDLE on a STOP write. STOP takes priority over START if both bits are set.
  - START in any state other than IDLE is ignored.
- Key and nonce writes while busy=1: ignored, keyerr set. In IDLE the write updates the word the next cycle.
- ACTIVE pacing:
  - gap counter loads RUN_GAP-1 on each run strobe and decrements to 0.
  - run_ctrout = ACTIVE & gap==0 & !inblockfifoempty_ctrin & !outblockfifofull_ctrin.
  - First run is possible in the cycle after SETNONCE.
- Block counter increments on each run strobe and wraps at 2^CNTW modulo.
  - CLRCNT clears it. CLRCNT and a run in the same cycle → result 1.
- DATA write:
  - inwordfifofull_ctrin=0: wren_ctrout=1 the same cycle; user_dataout=bus_wdata passes through combinationally.
  - FIFO full: no push, ovf set.
- DATA read:
  - outwordfifoempty_ctrin=0: bus_rdata=user_datain (FWFT) and rden_ctrout=1 the same cycle.
  - FIFO empty: bus_rdata=0, no pop, unf set.
- CLRERR clears ovf, unf and keyerr. A new error event in the same cycle wins (bit stays set).
- bus_we and bus_re together: both are honoured independently.
- Reset asserted mid-ACTIVE: FSM returns to IDLE next edge, no strobe that cycle.

Decomposition:
- Package aes256_pkg: register address constants (ADDR_KEY0..ADDR_DATA), CTRL and STATUS bit indices, FSM state enum.
- One sub-module, aes256_run_pacer: gap counter plus run-strobe qualification plus block counter.

Test Plan:
- Reset → all strobes 0, STATUS=0x0 plus flag bits, BLKCNT=0.
- Write key words 0–7 = 0x00010203…, nonce words 8–11, then CTRL=1 → setkey 1 cycle, setnonce on the next cycle, key_dataout matches, busy=1.
- ACTIVE with inblockempty=0 held and RUN_GAP=4 → run strobes exactly every 4 cycles. Set outblockfull=1 → run stops. Clear it → run resumes. After 10 runs, BLKCNT=10.
- Write DATA with inwordfull=1 → no wren, STATUS.ovf=1, irq=1. Write CTRL=8 → ovf=0, irq=0.
- Read DATA with outwordempty=0 and user_datain=0xDEADBEEF → bus_rdata=0xDEADBEEF with a one-cycle rden. With outwordempty=1 → bus_rdata=0, unf=1.
- Write a key word while ACTIVE → key unchanged, keyerr=1. CTRL=0x3 → FSM goes to IDLE, no new setkey strobe.
